instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL provide parameter DEPTH, default 1023, the instruction memory depth in 32-bit words.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 10, the program counter and load address width.
REQ-003 SHALL provide port clock_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port load_enable_in, input, 1 bit: writes load_data_in to memory this cycle.
REQ-006 SHALL provide port load_address_in, input, ADDR_WIDTH bits: memory write address.
REQ-007 SHALL provide port load_data_in, input, 32 bits: instruction word to store.
REQ-008 SHALL provide port start_in, input, 1 bit: begins a program run from address 0.
REQ-009 SHALL provide port stall_in, input, 1 bit: freezes issue for this cycle.
REQ-010 SHALL provide port current_instruction, output, 32 bits: the instruction fed to the CPU.
REQ-011 SHALL provide port program_counter_out, output, ADDR_WIDTH bits: address of the next word to issue.
REQ-012 SHALL provide port busy_out, output, 1 bit: high in RUN.
REQ-013 SHALL provide port done_out, output, 1 bit: one-cycle pulse at end of run.
REQ-014 SHALL provide port issued_count_out, output, 16 bits: instructions issued in the current or last run.

Function
REQ-015 SHALL hold DEPTH x 32 memory; write occurs on the edge when load_enable_in=1, busy_out=0 and load_address_in<DEPTH; otherwise the write is ignored.
REQ-016 SHALL implement states IDLE, RUN and DONE; IDLE->RUN on start_in=1; RUN->DONE on run end; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL, on the IDLE->RUN edge, set program_counter_out=0 and issued_count_out=0; start_in outside IDLE is ignored.
REQ-018 SHALL, in RUN with stall_in=0 and mem[pc]!=0, register current_instruction=mem[pc], increment pc, and increment issued_count_out (saturating at 16'hFFFF).
REQ-019 SHALL make the first instruction visible on current_instruction on the edge after the one that entered RUN.
REQ-020 SHALL, in RUN with stall_in=1, drive current_instruction=32'h00000008 (NOP) and hold pc and issued_count_out.
REQ-021 SHALL treat 32'h00000000 at mem[pc] as the terminator: drive NOP, do not count it, and end the run.
REQ-022 SHALL also end the run after issuing the word at pc=DEPTH-1.
REQ-023 SHALL drive current_instruction=NOP in IDLE and DONE; done_out=1 only in DONE.
REQ-024 SHALL give stall_in priority over terminator detection; a stalled cycle never ends the run.

Reset
REQ-025 SHALL, while reset_in=1, force state=IDLE, current_instruction=32'h00000008, program_counter_out=0, busy_out=0, done_out=0, issued_count_out=0, independent of clock.
REQ-026 SHALL NOT clear memory contents on reset; reset during RUN aborts the run without asserting done_out.

Configuration
REQ-027 SHALL compile looping under macro FETCH_LOOP_EN: when defined, a run end (terminator or pc=DEPTH-1) sets pc=0 and stays in RUN, unless the terminator is at address 0, which goes to DONE; when undefined, run end always goes to DONE per REQ-021/022.

Verification
REQ-028 SHALL pass: load mem[0..2]={32'h05000109,32'h0F010A09,0}, pulse start -> current_instruction 32'h05000109 then 32'h0F010A09 on consecutive cycles, then NOP, done_out one pulse, issued_count_out=2.
REQ-029 SHALL pass: same program, stall_in=1 for 3 cycles after the first issue -> three NOP cycles, pc holds at 1, second instruction issues after the stall, issued_count_out=2.
REQ-030 SHALL pass: load attempt with busy_out=1 to address 1 with 32'hDEADBEEF -> ignored; rerun issues original mem[1].
REQ-031 SHALL pass: reset_in asserted mid-run at pc=1 -> outputs take REQ-025 values immediately, no done_out; a new start reissues from mem[0].
REQ-032 SHALL pass: DEPTH=4, no terminator -> four issues, done_out after mem[3]; with FETCH_LOOP_EN, pc wraps to 0 and busy_out stays 1.
REQ-033 SHALL pass: mem[0]=0, start -> no issue, done_out pulses, issued_count_out=0, in both configurations.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory plus an IDLE/RUN/DONE sequencer.
// Define FETCH_LOOP_EN to restart from address 0 at run end instead of finishing.
module instruction_fetch_unit #(
   parameter int DEPTH      = 1023,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  load_enable_in,
   input  logic [ADDR_WIDTH-1:0] load_address_in,
   input  logic [31:0]           load_data_in,
   input  logic                  start_in,
   input  logic                  stall_in,
   output logic [31:0]           current_instruction,
   output logic [ADDR_WIDTH-1:0] program_counter_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [15:0]           issued_count_out
);

   localparam logic [1:0]            ST_IDLE   = 2'd0;
   localparam logic [1:0]            ST_RUN    = 2'd1;
   localparam logic [1:0]            ST_DONE   = 2'd2;
   localparam logic [31:0]           NOP       = 32'h0000_0008;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_ZERO   = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PC_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [31:0]           mem_q [DEPTH];
   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]           instr_q, instr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [31:0]           fetch_word_s;
   logic                  write_ok_s;

   // Write port qualification: loads are locked out while a run is in progress
   always_comb begin
      write_ok_s = 1'b0;
      if (load_enable_in && !busy_q && ({1'b0, load_address_in} < DEPTH_W)) begin
         write_ok_s = 1'b1;
      end else begin
         write_ok_s = 1'b0;
      end
   end

   // Instruction memory is deliberately outside reset so programs survive it
   always_ff @(posedge clock_in) begin
      if (write_ok_s) begin
         mem_q[load_address_in] <= load_data_in;
      end
   end

   // Read port; addresses past the end read as a terminator
   always_comb begin
      fetch_word_s = 32'h0000_0000;
      if ({1'b0, pc_q} < DEPTH_W) begin
         fetch_word_s = mem_q[pc_q];
      end else begin
         fetch_word_s = 32'h0000_0000;
      end
   end

   // Sequencer next-state: stall outranks terminator detection
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = NOP;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               state_d = ST_RUN;
               pc_d    = PC_ZERO;
               cnt_d   = 16'h0000;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stall_in) begin
               instr_d = NOP;
            end else if (fetch_word_s == 32'h0000_0000) begin
`ifdef FETCH_LOOP_EN
               if (pc_q != PC_ZERO) begin
                  pc_d = PC_ZERO;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end else begin
               instr_d = fetch_word_s;
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'h0001;
               end else begin
                  cnt_d = cnt_q;
               end
               if (pc_q == LAST_ADDR) begin
`ifdef FETCH_LOOP_EN
                  pc_d = PC_ZERO;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_ZERO;
         instr_q <= NOP;
         cnt_q   <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign current_instruction = instr_q;
   assign program_counter_out = pc_q;
   assign busy_out            = busy_q;
   assign done_out            = done_q;
   assign issued_count_out    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus hand sequences for
// reset abort, empty program and a 4-deep memory without terminator.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0008;
   localparam logic [31:0] IA  = 32'h0500_0109;
   localparam logic [31:0] IB  = 32'h0F01_0A09;

   logic        clk = 1'b0;
   logic        rst;
   logic        le, start, stall;
   logic [9:0]  addr;
   logic [31:0] data;
   logic [31:0] cur;
   logic [9:0]  pc;
   logic        busy, done;
   logic [15:0] cnt;

   logic        le4, start4, stall4;
   logic [1:0]  addr4;
   logic [31:0] data4;
   logic [31:0] cur4;
   logic [1:0]  pc4;
   logic        busy4, done4;
   logic [15:0] cnt4;

   int vec_count  = 0;
   int miss_count = 0;

   typedef struct {
      logic        le;
      logic [9:0]  addr;
      logic [31:0] data;
      logic        start;
      logic        stall;
      logic [31:0] e_cur;
      logic [9:0]  e_pc;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [22];

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clock_in(clk), .reset_in(rst), .load_enable_in(le), .load_address_in(addr),
      .load_data_in(data), .start_in(start), .stall_in(stall),
      .current_instruction(cur), .program_counter_out(pc), .busy_out(busy),
      .done_out(done), .issued_count_out(cnt)
   );

   instruction_fetch_unit #(.DEPTH(4), .ADDR_WIDTH(2)) dut4 (
      .clock_in(clk), .reset_in(rst), .load_enable_in(le4), .load_address_in(addr4),
      .load_data_in(data4), .start_in(start4), .stall_in(stall4),
      .current_instruction(cur4), .program_counter_out(pc4), .busy_out(busy4),
      .done_out(done4), .issued_count_out(cnt4)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vec_count++;
      if (got !== exp) begin
         miss_count++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [31:0] e_cur, input logic [9:0] e_pc,
                          input logic e_busy, input logic e_done, input logic [15:0] e_cnt);
      chk({nm, ".cur"},  cur, e_cur);
      chk({nm, ".pc"},   {22'd0, pc}, {22'd0, e_pc});
      chk({nm, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
      chk({nm, ".done"}, {31'd0, done}, {31'd0, e_done});
      chk({nm, ".cnt"},  {16'd0, cnt}, {16'd0, e_cnt});
   endtask

   initial begin
      //           le    addr   data          st    sl    cur  pc     bsy   dn    cnt
      tbl[0]  = '{1'b1, 10'd0, IA,           1'b0, 1'b0, NOP, 10'd0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 10'd1, IB,           1'b0, 1'b0, NOP, 10'd0, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 10'd2, 32'h0,        1'b0, 1'b0, NOP, 10'd0, 1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b0, 10'd0, 32'h0,        1'b1, 1'b0, NOP, 10'd0, 1'b1, 1'b0, 16'd0};
      tbl[4]  = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, IA,  10'd1, 1'b1, 1'b0, 16'd1};
      tbl[5]  = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, IB,  10'd2, 1'b1, 1'b0, 16'd2};
      tbl[6]  = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b1, 16'd2};
      tbl[7]  = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b0, 16'd2};
      // stalled run: three NOPs with pc parked at 1
      tbl[8]  = '{1'b0, 10'd0, 32'h0,        1'b1, 1'b0, NOP, 10'd0, 1'b1, 1'b0, 16'd0};
      tbl[9]  = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, IA,  10'd1, 1'b1, 1'b0, 16'd1};
      tbl[10] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b1, NOP, 10'd1, 1'b1, 1'b0, 16'd1};
      tbl[11] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b1, NOP, 10'd1, 1'b1, 1'b0, 16'd1};
      tbl[12] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b1, NOP, 10'd1, 1'b1, 1'b0, 16'd1};
      tbl[13] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, IB,  10'd2, 1'b1, 1'b0, 16'd2};
      tbl[14] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b1, 16'd2};
      tbl[15] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b0, 16'd2};
      // busy-time load ignored, start in RUN ignored, stall masks terminator
      tbl[16] = '{1'b0, 10'd0, 32'h0,        1'b1, 1'b0, NOP, 10'd0, 1'b1, 1'b0, 16'd0};
      tbl[17] = '{1'b1, 10'd1, 32'hDEADBEEF, 1'b0, 1'b0, IA,  10'd1, 1'b1, 1'b0, 16'd1};
      tbl[18] = '{1'b0, 10'd0, 32'h0,        1'b1, 1'b0, IB,  10'd2, 1'b1, 1'b0, 16'd2};
      tbl[19] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b1, NOP, 10'd2, 1'b1, 1'b0, 16'd2};
      tbl[20] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b1, 16'd2};
      tbl[21] = '{1'b0, 10'd0, 32'h0,        1'b0, 1'b0, NOP, 10'd2, 1'b0, 1'b0, 16'd2};

      rst = 1'b1; le = 1'b0; start = 1'b0; stall = 1'b0; addr = 10'd0; data = 32'h0;
      le4 = 1'b0; start4 = 1'b0; stall4 = 1'b0; addr4 = 2'd0; data4 = 32'h0;
      #1;
      chk_all("reset", NOP, 10'd0, 1'b0, 1'b0, 16'd0);
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         le = tbl[i].le; addr = tbl[i].addr; data = tbl[i].data;
         start = tbl[i].start; stall = tbl[i].stall;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_cur, tbl[i].e_pc,
                 tbl[i].e_busy, tbl[i].e_done, tbl[i].e_cnt);
      end
      le = 1'b0; start = 1'b0; stall = 1'b0;

      // reset mid-run at pc=1: immediate clear, no done pulse, clean restart
      start = 1'b1; step(); start = 1'b0;
      step();
      chk_all("pre_rst", IA, 10'd1, 1'b1, 1'b0, 16'd1);
      #2 rst = 1'b1;
      #1 chk_all("async_rst", NOP, 10'd0, 1'b0, 1'b0, 16'd0);
      step();
      rst = 1'b0;
      step();
      chk_all("post_rst", NOP, 10'd0, 1'b0, 1'b0, 16'd0);
      start = 1'b1; step(); start = 1'b0;
      step();
      chk_all("rerun", IA, 10'd1, 1'b1, 1'b0, 16'd1);
      step(); step(); step();
      chk_all("rerun_end", NOP, 10'd2, 1'b0, 1'b0, 16'd2);

      // empty program: terminator at address 0
      le = 1'b1; addr = 10'd0; data = 32'h0; step(); le = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();
      chk_all("empty_done", NOP, 10'd0, 1'b0, 1'b1, 16'd0);
      step();
      chk_all("empty_idle", NOP, 10'd0, 1'b0, 1'b0, 16'd0);

      // DEPTH=4 with no terminator
      for (int i = 0; i < 4; i++) begin
         le4 = 1'b1; addr4 = 2'(i); data4 = 32'h11 * (i + 1); step();
      end
      le4 = 1'b0;
      start4 = 1'b1; step(); start4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("d4_cur%0d", i), cur4, 32'h11 * (i + 1));
         chk($sformatf("d4_cnt%0d", i), {16'd0, cnt4}, i + 1);
      end
`ifdef FETCH_LOOP_EN
      chk("d4_busy_wrap", {31'd0, busy4}, 32'd1);
      chk("d4_done_wrap", {31'd0, done4}, 32'd0);
      chk("d4_pc_wrap", {30'd0, pc4}, 32'd0);
      step();
      chk("d4_cur_wrap", cur4, 32'h11);
      chk("d4_cnt_wrap", {16'd0, cnt4}, 32'd5);
`else
      chk("d4_done", {31'd0, done4}, 32'd1);
      chk("d4_busy", {31'd0, busy4}, 32'd0);
      step();
      chk("d4_done_end", {31'd0, done4}, 32'd0);
      chk("d4_cur_end", cur4, NOP);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
